// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM state encoding, register index width,
// and the per-stage RAW hazard test used by the hazard controller.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // A stage hazards when it will write a non-x0 register that the ID instruction reads.
  function automatic logic stage_hazard(
    input logic [REG_W-1:0] rd,
    input logic             reg_write,
    input logic [REG_W-1:0] rs1,
    input logic             use_rs1,
    input logic [REG_W-1:0] rs2,
    input logic             use_rs2
  );
    return reg_write && (rd != '0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage register info in, pipeline
// enables/bubbles and performance counters out.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  import pipe_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [REG_W-1:0] mem_rd;
  logic             mem_reg_write;
  logic             mem_branch_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_reg_write, ex_mem_read,
    output mem_rd, mem_reg_write, mem_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_reg_write, ex_mem_read,
    input  mem_rd, mem_reg_write, mem_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous reset wins.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: RAW stalls, taken-branch flushes, perf counters.
// Define FORWARDING_EN to stall only on load-use (one cycle) instead of any EX/MEM RAW hazard.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);
  import pipe_pkg::*;

  hz_state_e state;
  logic      hz_ex, hz_mem, load_use, stall_req;
  logic      stall_inc, flush_inc;

  always_comb begin
    hz_ex    = stage_hazard(bus.ex_rd, bus.ex_reg_write, bus.id_rs1, bus.id_use_rs1,
                            bus.id_rs2, bus.id_use_rs2);
    hz_mem   = stage_hazard(bus.mem_rd, bus.mem_reg_write, bus.id_rs1, bus.id_use_rs1,
                            bus.id_rs2, bus.id_use_rs2);
    load_use = bus.ex_mem_read && hz_ex;
`ifdef FORWARDING_EN
    // Once stalled, the load has moved on to MEM and its result can be forwarded.
    stall_req = load_use && (state != ST_STALL);
`else
    // Without bypassing, any in-flight producer blocks ID; WB needs no stall
    // because the register file writes before it reads.
    stall_req = load_use || hz_ex || hz_mem;
`endif
  end

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    if (!reset) begin
      if (bus.mem_branch_taken) begin
        bus.ifid_flush  = 1'b1;
        bus.idex_flush  = 1'b1;
        bus.exmem_flush = 1'b1;
        flush_inc       = 1'b1;
      end else if (state != ST_FLUSH && stall_req) begin
        // ID instruction in a FLUSH cycle is a bubble, so its hazards are ignored.
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.idex_flush  = 1'b1;
        stall_inc       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_RUN;
    else if (bus.mem_branch_taken)
      state <= ST_FLUSH;
    else if (stall_inc)
      state <= ST_STALL;
    else
      state <= ST_RUN;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .cnt   (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .cnt   (bus.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random check of hazard_ctrl; a 32-bit and a 4-bit-counter instance share stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic       use1, use2, ex_we, ex_ld, mem_we, br;

  int n_chk = 0;
  int n_err = 0;

  // Reference: a branch leaves a bubble in ID next cycle; counters are event counts.
  bit     m_pend, m_stl;
  longint m_sc, m_fc;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) b32 ();
  hazard_ctrl_if #(.CNT_W(4))  b4 ();

  assign b32.id_rs1 = rs1;           assign b4.id_rs1 = rs1;
  assign b32.id_rs2 = rs2;           assign b4.id_rs2 = rs2;
  assign b32.id_use_rs1 = use1;      assign b4.id_use_rs1 = use1;
  assign b32.id_use_rs2 = use2;      assign b4.id_use_rs2 = use2;
  assign b32.ex_rd = ex_rd;          assign b4.ex_rd = ex_rd;
  assign b32.ex_reg_write = ex_we;   assign b4.ex_reg_write = ex_we;
  assign b32.ex_mem_read = ex_ld;    assign b4.ex_mem_read = ex_ld;
  assign b32.mem_rd = mem_rd;        assign b4.mem_rd = mem_rd;
  assign b32.mem_reg_write = mem_we; assign b4.mem_reg_write = mem_we;
  assign b32.mem_branch_taken = br;  assign b4.mem_branch_taken = br;

  hazard_ctrl #(.CNT_W(32)) dut32 (.clk(clk), .reset(rst), .bus(b32.slave));
  hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .reset(rst), .bus(b4.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] rd, input logic we);
    return we && rd != 5'd0 && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

  task automatic set_in(input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                        input logic u2, input logic [4:0] erd, input logic ewe,
                        input logic eld, input logic [4:0] mrd, input logic mwe,
                        input logic b, input logic r);
    rs1 = a1; use1 = u1; rs2 = a2; use2 = u2;
    ex_rd = erd; ex_we = ewe; ex_ld = eld;
    mem_rd = mrd; mem_we = mwe; br = b; rst = r;
  endtask

  // One clock: check outputs against the reference mid-cycle, then advance the reference.
  task automatic cycle(input string tag);
    bit need, stall;
    logic [4:0] exp;
    @(negedge clk);
    #1;
`ifdef FORWARDING_EN
    need = ex_ld && hit(ex_rd, ex_we) && !m_stl;
`else
    need = hit(ex_rd, ex_we) || hit(mem_rd, mem_we);
`endif
    stall = !rst && !br && !m_pend && need;
    if (rst)        exp = 5'b11000;
    else if (br)    exp = 5'b11111;
    else if (stall) exp = 5'b00010;
    else            exp = 5'b11000;
    chk({tag, ".out32"}, {b32.pc_write, b32.ifid_write, b32.ifid_flush, b32.idex_flush,
                          b32.exmem_flush}, exp);
    chk({tag, ".out4"}, {b4.pc_write, b4.ifid_write, b4.ifid_flush, b4.idex_flush,
                         b4.exmem_flush}, exp);
    chk({tag, ".scnt32"}, b32.stall_cnt, m_sc);
    chk({tag, ".fcnt32"}, b32.flush_cnt, m_fc);
    chk({tag, ".scnt4"}, b4.stall_cnt, (m_sc > 15) ? 15 : m_sc);
    chk({tag, ".fcnt4"}, b4.flush_cnt, (m_fc > 15) ? 15 : m_fc);
    if (rst) begin
      m_sc = 0; m_fc = 0; m_pend = 0; m_stl = 0;
    end else begin
      m_sc += stall;
      m_fc += br;
      m_pend = br;
      m_stl = stall;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r);
  endtask

  initial begin
    m_pend = 0; m_stl = 0; m_sc = 0; m_fc = 0;
    idle(1);
    cycle("reset");
    cycle("reset2");

    // Load-use on rs1=x5: one stall cycle, then EX holds a bubble
    set_in(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    cycle("loaduse");
    idle(0);
    cycle("loaduse_after");
    chk("loaduse_cnt", b32.stall_cnt, 1);

    // x0 is never a hazard
    set_in(0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0);
    cycle("x0");
    chk("x0_cnt", b32.stall_cnt, 1);

    // Branch during a stall, then the FLUSH cycle ignores the same hazard
    set_in(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    cycle("pre_branch_stall");
    br = 1;
    cycle("branch_in_stall");
    br = 0;
    cycle("flush_ignores_hz");
    chk("branch_fcnt", b32.flush_cnt, 1);
    idle(0);
    cycle("post_flush");

    // ALU producer x7 seen in EX then MEM: two stall cycles
    idle(1);
    cycle("rst_a");
    set_in(0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0);
    cycle("alu_ex");
    set_in(0, 0, 7, 1, 0, 0, 0, 7, 1, 0, 0);
    cycle("alu_mem");
    set_in(0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle("alu_wb");
    chk("alu_cnt", b32.stall_cnt, 2);

    // Long stall: the 4-bit counter saturates at 15
    idle(1);
    cycle("rst_b");
    set_in(9, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle("long_stall");
    chk("sat32", b32.stall_cnt, 20);
    chk("sat4", b4.stall_cnt, 15);
    cycle("still_sat");

    // Reset while stalled (hazard and branch still asserted) clears everything
    rst = 1;
    br = 1;
    cycle("reset_mid_stall");
    idle(0);
    cycle("after_reset");
    chk("after_reset_cnt", b32.stall_cnt, 0);

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rs1, id_rs2  in  5 each  ID-stage source registers.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2.
- ex_rd  in  5  EX-stage destination.
- ex_reg_write, ex_mem_read  in  1 each  EX writes register / EX is a load.
- mem_rd  in  5  MEM-stage destination.
- mem_reg_write  in  1  MEM writes register.
- mem_branch_taken  in  1  branch resolved taken in MEM.
- pc_write, ifid_write  out  1 each  enable PC / IF-ID update.
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert bubble.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-003 SHALL implement registered states RUN, STALL, FLUSH; reset state RUN.
REQ-004 SHALL define hazard(stage) true iff the stage reg_write=1, its rd≠0, and rd equals a used ID source; rd=0 never hazards.
REQ-005 SHALL, when mem_branch_taken=1 in any state, assert ifid_flush, idex_flush, exmem_flush and pc_write=1, ifid_write=1 that cycle; next state FLUSH; branch overrides any stall.
REQ-006 SHALL, in FLUSH, ignore hazards for exactly one cycle (ID contents are a bubble), drive pc_write=ifid_write=1, all flushes 0, and return to RUN unless mem_branch_taken=1.
REQ-007 SHALL, in RUN/STALL with a required stall (REQ-011/012) and no branch, drive pc_write=0, ifid_write=0, idex_flush=1, other flushes 0; next state STALL.
REQ-008 SHALL, with no stall and no branch, drive pc_write=ifid_write=1, all flushes 0; next state RUN.
REQ-009 SHALL produce all outputs combinationally from current state and inputs (zero-cycle latency); only state and counters are registered.
REQ-010 SHALL increment stall_cnt on every cycle REQ-007 applies and flush_cnt on every cycle mem_branch_taken=1; both saturate at 2^CNT_W-1, never wrap.

Configuration
REQ-011 SHALL, with FORWARDING_EN defined, require a stall only for load-use: ex_mem_read=1 and hazard(EX); maximum one consecutive stall cycle per instruction.
REQ-012 SHALL, without FORWARDING_EN, require a stall on hazard(EX) or hazard(MEM), holding until neither holds (up to two cycles; WB written first-half, read second-half, needs no stall).

Reset
REQ-013 SHALL, with reset=1 at a clock edge, set state RUN, stall_cnt=0, flush_cnt=0, overriding branch or stall activity that cycle.
REQ-014 SHALL, while reset=1, drive pc_write=ifid_write=1 and all flushes 0.

Structure
REQ-015 SHALL place state encoding (2-bit) and register-index width constant (5) in the shared package pipe_pkg.
REQ-016 SHALL implement saturating counters through one sub-module sat_counter (parameter CNT_W, inputs clk, reset, inc), instantiated twice.

Verification
REQ-017 Load-use: ex_mem_read=1, ex_rd=5, ex_reg_write=1, id_rs1=5, id_use_rs1=1 -> one cycle pc_write=0, idex_flush=1, stall_cnt=1; next cycle RUN.
REQ-018 x0: ex_rd=0, load, id_rs1=0 -> no stall, stall_cnt unchanged.
REQ-019 Branch during stall: stall condition plus mem_branch_taken=1 -> three flushes=1, pc_write=1; next cycle FLUSH ignores hazard; flush_cnt=1.
REQ-020 No FORWARDING_EN: ALU op ex_rd=7, id_rs2=7 used -> stall two cycles (EX then MEM match), stall_cnt=2.
REQ-021 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt holds 15.
REQ-022 Reset mid-STALL: reset=1 -> next cycle state RUN, counters 0, pc_write=1.
